// File: rtl/decode_stage_pkg.sv
// Shared encodings for the RV32I+Zicsr decode stage: opcodes, ALU ops, writeback selects
// and the packed control bundle carried from decode into EX.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_CSR = 2'd3;

  localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
  localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
  localparam logic [31:0] MRET_WORD   = 32'h3020_0073;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_funct3;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [2:0] csr_op;
    logic       illegal;
    logic       ecall;
    logic       ebreak;
    logic       mret;
    logic       fence;
  } ctrl_t;

  // alt selects SUB/SRA; callers only raise it where funct7[5] is meaningful
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: picks the RV32I immediate format from the opcode and sign-extends,
// except CSR*I which zero-extends the 5-bit uimm field.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [31:0] o_imm
);

  logic [6:0] w_opcode;
  assign w_opcode = i_inst[6:0];

  always_comb begin
    o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: o_imm = {i_inst[31:12], 12'b0};
      OPC_JAL:    o_imm = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      OPC_BRANCH: o_imm = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      OPC_STORE:  o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      OPC_SYSTEM: if (i_inst[14]) o_imm = {27'b0, i_inst[19:15]};
      default:    o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I+Zicsr decode stage: combinational regfile addressing and load-use hazard detect,
// registered ID/EX bundle with stall hold and bubble insertion.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic [4:0]      i_ex_rd,
  input  logic            i_ex_mem_read,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  output logic            o_hazard_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_imm,
  output logic [3:0]      o_alu_op,
  output logic            o_alu_src_imm,
  output logic            o_alu_src_pc,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic [2:0]      o_mem_funct3,
  output logic            o_reg_write,
  output logic [1:0]      o_wb_sel,
  output logic            o_branch,
  output logic            o_jal,
  output logic            o_jalr,
  output logic [2:0]      o_csr_op,
  output logic [11:0]     o_csr_addr,
  output logic            o_illegal,
  output logic            o_ecall,
  output logic            o_ebreak,
  output logic            o_mret,
  output logic            o_fence
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  logic        w_illegal;
  logic        w_csr_imm;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  ctrl_t       w_ctrl;

  assign w_opcode   = i_inst[6:0];
  assign w_rd       = i_inst[11:7];
  assign w_funct3   = i_inst[14:12];
  assign w_funct7   = i_inst[31:25];
  assign o_rs1_addr = i_inst[19:15];
  assign o_rs2_addr = i_inst[24:20];

  decode_stage_imm_gen u_imm_gen (
    .i_inst (i_inst),
    .o_imm  (w_imm)
  );

  assign w_csr_imm  = (w_opcode == OPC_SYSTEM) && w_funct3[2] && (w_funct3[1:0] != 2'b00);
  assign w_uses_rs1 = !((w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) ||
                        (w_opcode == OPC_JAL) || w_csr_imm);
  assign w_uses_rs2 = (w_opcode == OPC_OP) || (w_opcode == OPC_STORE) || (w_opcode == OPC_BRANCH);

  assign o_hazard_stall = !i_flush && i_ex_mem_read && (i_ex_rd != 5'd0) &&
                          ((w_uses_rs1 && (o_rs1_addr == i_ex_rd)) ||
                           (w_uses_rs2 && (o_rs2_addr == i_ex_rd)));

  always_comb begin
    w_ctrl    = '0;
    w_illegal = (i_inst[1:0] != 2'b11);
    case (w_opcode)
      OPC_LUI: begin
        w_ctrl.alu_op = ALU_PASSB; w_ctrl.alu_src_imm = 1'b1; w_ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_ctrl.alu_src_imm = 1'b1; w_ctrl.alu_src_pc = 1'b1; w_ctrl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        w_ctrl.alu_src_imm = 1'b1; w_ctrl.alu_src_pc = 1'b1; w_ctrl.reg_write = 1'b1;
        w_ctrl.wb_sel = WB_PC4; w_ctrl.jal = 1'b1;
      end
      OPC_JALR: begin
        w_ctrl.alu_src_imm = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.wb_sel = WB_PC4;
        w_ctrl.jalr = 1'b1;
        w_illegal = w_illegal || (w_funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_op = w_funct3[2] ? (w_funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        w_illegal = w_illegal || (w_funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        w_ctrl.alu_src_imm = 1'b1; w_ctrl.mem_read = 1'b1; w_ctrl.mem_funct3 = w_funct3;
        w_ctrl.reg_write = 1'b1; w_ctrl.wb_sel = WB_MEM;
        w_illegal = w_illegal || (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        w_ctrl.alu_src_imm = 1'b1; w_ctrl.mem_write = 1'b1; w_ctrl.mem_funct3 = w_funct3;
        w_illegal = w_illegal || (w_funct3 > 3'b010);
      end
      OPC_OP_IMM: begin
        w_ctrl.alu_src_imm = 1'b1; w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
        if (w_funct3 == 3'b001) w_illegal = w_illegal || (w_funct7 != 7'h00);
        if (w_funct3 == 3'b101) w_illegal = w_illegal || ((w_funct7 != 7'h00) && (w_funct7 != 7'h20));
      end
      OPC_OP: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op = alu_from_funct3(w_funct3, w_funct7[5]);
        if (w_funct7 == 7'h20)
          w_illegal = w_illegal || !((w_funct3 == 3'b000) || (w_funct3 == 3'b101));
        else
          w_illegal = w_illegal || (w_funct7 != 7'h00);
      end
      OPC_MISCMEM: w_ctrl.fence = 1'b1;
      OPC_SYSTEM: begin
        if (w_funct3 == 3'b000) begin
          w_ctrl.ecall  = (i_inst == ECALL_WORD);
          w_ctrl.ebreak = (i_inst == EBREAK_WORD);
          w_ctrl.mret   = (i_inst == MRET_WORD);
          w_illegal = !(w_ctrl.ecall || w_ctrl.ebreak || w_ctrl.mret);
        end else if (w_funct3 == 3'b100) begin
          w_illegal = 1'b1;
        end else begin
          w_ctrl.csr_op = w_funct3; w_ctrl.reg_write = 1'b1; w_ctrl.wb_sel = WB_CSR;
        end
      end
      default: w_illegal = 1'b1;
    endcase
    // An illegal word still occupies the slot so EX can raise the trap, but has no effects
    if (w_illegal) begin
      w_ctrl.mem_read = 1'b0; w_ctrl.mem_write = 1'b0; w_ctrl.reg_write = 1'b0;
      w_ctrl.branch   = 1'b0; w_ctrl.jal       = 1'b0; w_ctrl.jalr      = 1'b0;
      w_ctrl.csr_op   = 3'b000;
    end
    w_ctrl.illegal = w_illegal;
    if (w_rd == 5'd0) w_ctrl.reg_write = 1'b0;
  end

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0] r_imm;
  logic [11:0]     r_csr_addr;
  ctrl_t           r_ctrl;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0; r_pc <= RESET_PC; r_rs1 <= '0; r_rs2 <= '0; r_rd <= '0;
      r_imm <= '0; r_csr_addr <= '0; r_ctrl <= '0;
    end else if (!i_stall) begin
      if (i_flush || o_hazard_stall) begin
        r_valid <= 1'b0; r_pc <= '0; r_rs1 <= '0; r_rs2 <= '0; r_rd <= '0;
        r_imm <= '0; r_csr_addr <= '0; r_ctrl <= '0;
      end else begin
        r_valid <= 1'b1; r_pc <= i_pc; r_rs1 <= o_rs1_addr; r_rs2 <= o_rs2_addr;
        r_rd <= w_rd; r_imm <= w_imm; r_csr_addr <= i_inst[31:20]; r_ctrl <= w_ctrl;
      end
    end
  end

  assign o_valid       = r_valid;
  assign o_pc          = r_pc;
  assign o_rs1         = r_rs1;
  assign o_rs2         = r_rs2;
  assign o_rd          = r_rd;
  assign o_imm         = r_imm;
  assign o_csr_addr    = r_csr_addr;
  assign o_alu_op      = r_ctrl.alu_op;
  assign o_alu_src_imm = r_ctrl.alu_src_imm;
  assign o_alu_src_pc  = r_ctrl.alu_src_pc;
  assign o_mem_read    = r_ctrl.mem_read;
  assign o_mem_write   = r_ctrl.mem_write;
  assign o_mem_funct3  = r_ctrl.mem_funct3;
  assign o_reg_write   = r_ctrl.reg_write;
  assign o_wb_sel      = r_ctrl.wb_sel;
  assign o_branch      = r_ctrl.branch;
  assign o_jal         = r_ctrl.jal;
  assign o_jalr        = r_ctrl.jalr;
  assign o_csr_op      = r_ctrl.csr_op;
  assign o_illegal     = r_ctrl.illegal;
  assign o_ecall       = r_ctrl.ecall;
  assign o_ebreak      = r_ctrl.ebreak;
  assign o_mret        = r_ctrl.mret;
  assign o_fence       = r_ctrl.fence;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases plus random instruction streams compared
// against an arithmetic/table reference decoder and a hold/bubble model of the ID/EX bundle.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        i_clk, i_rst_n, i_stall, i_flush, i_ex_mem_read;
  logic [31:0] i_inst, i_pc;
  logic [4:0]  i_ex_rd;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rs1, o_rs2, o_rd;
  logic        o_hazard_stall, o_valid, o_alu_src_imm, o_alu_src_pc, o_mem_read, o_mem_write;
  logic        o_reg_write, o_branch, o_jal, o_jalr, o_illegal, o_ecall, o_ebreak, o_mret, o_fence;
  logic [31:0] o_pc, o_imm;
  logic [3:0]  o_alu_op;
  logic [2:0]  o_mem_funct3, o_csr_op;
  logic [1:0]  o_wb_sel;
  logic [11:0] o_csr_addr;

  decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_inst(i_inst), .i_pc(i_pc), .i_ex_rd(i_ex_rd), .i_ex_mem_read(i_ex_mem_read),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_hazard_stall(o_hazard_stall),
    .o_valid(o_valid), .o_pc(o_pc), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_imm(o_imm),
    .o_alu_op(o_alu_op), .o_alu_src_imm(o_alu_src_imm), .o_alu_src_pc(o_alu_src_pc),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_funct3(o_mem_funct3),
    .o_reg_write(o_reg_write), .o_wb_sel(o_wb_sel), .o_branch(o_branch), .o_jal(o_jal),
    .o_jalr(o_jalr), .o_csr_op(o_csr_op), .o_csr_addr(o_csr_addr), .o_illegal(o_illegal),
    .o_ecall(o_ecall), .o_ebreak(o_ebreak), .o_mret(o_mret), .o_fence(o_fence)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        src_imm, src_pc, mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        branch, jal, jalr;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic        illegal, ecall, ebreak, mret, fence;
    bit          m_aluop, m_src, m_wb, m_imm, m_mf3;
  } exp_t;

  int   n_checks, n_errors;
  exp_t exp_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t quiet_exp(input logic [31:0] pc);
    exp_t e;
    e = '{default: '0};
    e.pc = pc;
    e.m_aluop = 1; e.m_src = 1; e.m_wb = 1; e.m_imm = 1; e.m_mf3 = 1;
    return e;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t        e;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] sx, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0]  tbl [8];
    bit          ill;
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    sx    = {32{inst[31]}};
    imm_i = (sx << 12) | 32'(inst[31:20]);
    imm_s = (sx << 12) | (32'(inst[31:25]) << 5) | 32'(inst[11:7]);
    imm_b = (sx << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
    imm_u = inst & 32'hFFFF_F000;
    imm_j = (sx << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
    ill = (inst[1:0] != 2'b11);
    e = quiet_exp(pc);
    e.valid = 1; e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7];
    e.csr_addr = inst[31:20]; e.m_mf3 = 0;
    case (op)
      7'h37: begin e.imm = imm_u; e.alu_op = ALU_PASSB; e.src_imm = 1; e.reg_write = 1; e.wb_sel = WB_ALU; end
      7'h17: begin e.imm = imm_u; e.alu_op = ALU_ADD; e.src_imm = 1; e.src_pc = 1; e.reg_write = 1; e.wb_sel = WB_ALU; end
      7'h6f: begin e.imm = imm_j; e.alu_op = ALU_ADD; e.src_imm = 1; e.src_pc = 1; e.reg_write = 1; e.wb_sel = WB_PC4; e.jal = 1; end
      7'h67: begin
        e.imm = imm_i; e.alu_op = ALU_ADD; e.src_imm = 1; e.reg_write = 1; e.wb_sel = WB_PC4; e.jalr = 1;
        if (f3 != 0) ill = 1;
      end
      7'h63: begin
        e.imm = imm_b; e.branch = 1; e.m_aluop = 0; e.m_wb = 0;
        if (f3 == 2 || f3 == 3) ill = 1;
      end
      7'h03: begin
        e.imm = imm_i; e.alu_op = ALU_ADD; e.src_imm = 1; e.mem_read = 1; e.mem_funct3 = f3;
        e.m_mf3 = 1; e.reg_write = 1; e.wb_sel = WB_MEM;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ill = 1;
      end
      7'h23: begin
        e.imm = imm_s; e.alu_op = ALU_ADD; e.src_imm = 1; e.mem_write = 1; e.mem_funct3 = f3;
        e.m_mf3 = 1; e.m_wb = 0;
        if (f3 > 2) ill = 1;
      end
      7'h13: begin
        e.imm = imm_i; e.src_imm = 1; e.reg_write = 1; e.wb_sel = WB_ALU; e.alu_op = tbl[f3];
        if (f3 == 5 && f7 == 7'h20) e.alu_op = ALU_SRA;
        if (f3 == 1 && f7 != 0) ill = 1;
        if (f3 == 5 && !(f7 inside {7'h00, 7'h20})) ill = 1;
      end
      7'h33: begin
        e.m_imm = 0; e.reg_write = 1; e.wb_sel = WB_ALU; e.alu_op = tbl[f3];
        if (f7 == 7'h20) begin
          if (f3 == 0) e.alu_op = ALU_SUB;
          else if (f3 == 5) e.alu_op = ALU_SRA;
          else ill = 1;
        end else if (f7 != 0) ill = 1;
      end
      7'h0f: begin e.fence = 1; e.m_aluop = 0; e.m_src = 0; e.m_wb = 0; e.m_imm = 0; end
      7'h73: begin
        e.m_aluop = 0; e.m_src = 0;
        if (f3 == 0) begin
          e.m_wb = 0; e.m_imm = 0;
          if (inst == 32'h0000_0073) e.ecall = 1;
          else if (inst == 32'h0010_0073) e.ebreak = 1;
          else if (inst == 32'h3020_0073) e.mret = 1;
          else ill = 1;
        end else if (f3 == 4) ill = 1;
        else begin
          e.csr_op = f3; e.reg_write = 1; e.wb_sel = WB_CSR;
          e.imm = (f3 >= 5) ? 32'(inst[19:15]) : imm_i;
        end
      end
      default: ill = 1;
    endcase
    if (ill) begin
      e.illegal = 1; e.mem_read = 0; e.mem_write = 0; e.reg_write = 0; e.branch = 0;
      e.jal = 0; e.jalr = 0; e.csr_op = 0;
      e.m_aluop = 0; e.m_src = 0; e.m_wb = 0; e.m_imm = 0; e.m_mf3 = 0;
    end
    if (e.rd == 0) e.reg_write = 0;
    return e;
  endfunction

  function automatic logic ref_hazard(input logic [31:0] inst, input logic [4:0] ex_rd,
                                      input logic ex_mem, input logic flush);
    logic [6:0] op;
    logic       u1, u2;
    op = inst[6:0];
    u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f ||
           (op == 7'h73 && inst[14:12] inside {3'd5, 3'd6, 3'd7}));
    u2 = op inside {7'h33, 7'h23, 7'h63};
    return !flush && ex_mem && (ex_rd != 0) &&
           ((u1 && inst[19:15] == ex_rd) || (u2 && inst[24:20] == ex_rd));
  endfunction

  task automatic check_bundle();
    check("valid", o_valid, exp_q.valid);
    check("pc", o_pc, exp_q.pc);
    check("rs1", o_rs1, exp_q.rs1);
    check("rs2", o_rs2, exp_q.rs2);
    check("rd", o_rd, exp_q.rd);
    if (exp_q.m_imm) check("imm", o_imm, exp_q.imm);
    if (exp_q.m_aluop) check("alu_op", o_alu_op, exp_q.alu_op);
    if (exp_q.m_src) begin
      check("src_imm", o_alu_src_imm, exp_q.src_imm);
      check("src_pc", o_alu_src_pc, exp_q.src_pc);
    end
    check("mem_read", o_mem_read, exp_q.mem_read);
    check("mem_write", o_mem_write, exp_q.mem_write);
    if (exp_q.m_mf3) check("mem_funct3", o_mem_funct3, exp_q.mem_funct3);
    check("reg_write", o_reg_write, exp_q.reg_write);
    if (exp_q.m_wb) check("wb_sel", o_wb_sel, exp_q.wb_sel);
    check("branch", o_branch, exp_q.branch);
    check("jal", o_jal, exp_q.jal);
    check("jalr", o_jalr, exp_q.jalr);
    check("csr_op", o_csr_op, exp_q.csr_op);
    check("csr_addr", o_csr_addr, exp_q.csr_addr);
    check("illegal", o_illegal, exp_q.illegal);
    check("ecall", o_ecall, exp_q.ecall);
    check("ebreak", o_ebreak, exp_q.ebreak);
    check("mret", o_mret, exp_q.mret);
    check("fence", o_fence, exp_q.fence);
  endtask

  // Called in the low clock phase; returns at the following negedge.
  task automatic cycle(input logic [31:0] inst, input logic [31:0] pc, input logic stall,
                       input logic flush, input logic [4:0] ex_rd, input logic ex_mem);
    logic hz;
    i_inst = inst; i_pc = pc; i_stall = stall; i_flush = flush;
    i_ex_rd = ex_rd; i_ex_mem_read = ex_mem;
    #1;
    hz = ref_hazard(inst, ex_rd, ex_mem, flush);
    check("rs1_addr", o_rs1_addr, inst[19:15]);
    check("rs2_addr", o_rs2_addr, inst[24:20]);
    check("hazard", o_hazard_stall, hz);
    if (!stall) exp_q = (flush || hz) ? quiet_exp(32'h0) : ref_decode(inst, pc);
    @(posedge i_clk);
    #1;
    check_bundle();
    @(negedge i_clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int          sel;
    w   = $urandom;
    sel = $urandom_range(0, 23);
    case (sel)
      0:          w[6:0] = 7'h37;
      1:          w[6:0] = 7'h17;
      2:          w[6:0] = 7'h6f;
      3:          w[6:0] = 7'h67;
      4, 5:       w[6:0] = 7'h63;
      6, 7:       w[6:0] = 7'h03;
      8:          w[6:0] = 7'h23;
      9, 10, 11:  w[6:0] = 7'h13;
      12, 13, 14: w[6:0] = 7'h33;
      15:         w[6:0] = 7'h0f;
      16, 17:     w[6:0] = 7'h73;
      18:         w = 32'h0000_0073;
      19:         w = 32'h0010_0073;
      20:         w = 32'h3020_0073;
      default:    ;
    endcase
    if (sel <= 17 && $urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if (sel <= 17 && $urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    logic [31:0] ri;
    logic [4:0]  rx;
    int          pick;
    n_checks = 0; n_errors = 0;
    i_rst_n = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_inst = '0; i_pc = '0;
    i_ex_rd = '0; i_ex_mem_read = 1'b0;
    #1 i_rst_n = 1'b0;
    #1;
    exp_q = quiet_exp(RST_PC);
    check_bundle();
    @(negedge i_clk);
    i_rst_n = 1'b1;

    cycle(32'hFFD0_8293, 32'h100, 0, 0, 5'd0, 0);
    check("addi_valid", o_valid, 1);
    check("addi_rd", o_rd, 5);
    check("addi_rs1", o_rs1, 1);
    check("addi_imm", o_imm, 32'hFFFF_FFFD);
    check("addi_alu", o_alu_op, ALU_ADD);
    check("addi_src_imm", o_alu_src_imm, 1);
    check("addi_reg_write", o_reg_write, 1);
    check("addi_pc", o_pc, 32'h100);

    cycle(32'hFE20_8CE3, 32'h104, 0, 0, 5'd0, 0);
    check("beq_branch", o_branch, 1);
    check("beq_imm", o_imm, 32'hFFFF_FFF8);
    check("beq_reg_write", o_reg_write, 0);
    check("beq_rs2", o_rs2, 2);

    cycle(32'h0072_8333, 32'h108, 0, 0, 5'd5, 1);
    check("lu_stall", o_hazard_stall, 1);
    check("lu_bubble", o_valid, 0);
    cycle(32'h0072_8333, 32'h108, 0, 0, 5'd0, 1);
    check("lu_release", o_hazard_stall, 0);
    check("lu_add_valid", o_valid, 1);
    check("lu_add_rd", o_rd, 6);

    cycle(32'h3002_11F3, 32'h10C, 0, 0, 5'd0, 0);
    check("csr_op", o_csr_op, 1);
    check("csr_addr_val", o_csr_addr, 12'h300);
    check("csr_wb", o_wb_sel, WB_CSR);
    check("csr_rd", o_rd, 3);
    cycle(32'h0000_0000, 32'h110, 0, 0, 5'd0, 0);
    check("zero_illegal", o_illegal, 1);
    check("zero_valid", o_valid, 1);
    check("zero_enables", {o_mem_read, o_mem_write, o_reg_write, o_branch, o_jal, o_jalr, o_csr_op}, 0);

    cycle(32'h0000_0013, 32'h114, 1, 1, 5'd0, 0);
    cycle(32'h0000_0013, 32'h114, 1, 1, 5'd0, 0);
    check("stall_hold_illegal", o_illegal, 1);
    check("stall_hold_pc", o_pc, 32'h110);
    cycle(32'h0000_0013, 32'h114, 0, 1, 5'd0, 0);
    check("flush_bubble", o_valid, 0);

    cycle(NOP_WORD, 32'h118, 0, 0, 5'd0, 0);
    check("nop_valid", o_valid, 1);
    check("nop_reg_write", o_reg_write, 0);

    for (int n = 0; n < 600; n++) begin
      ri   = rand_inst();
      pick = $urandom_range(0, 3);
      rx   = (pick == 0) ? ri[19:15] : (pick == 1) ? ri[24:20] : 5'($urandom);
      cycle(ri, {$urandom, 2'b00} , ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
            rx, ($urandom_range(0, 1) == 1));
    end

    cycle(32'h0020_8093, 32'h200, 0, 0, 5'd0, 0);
    i_stall = 1'b1;
    #2 i_rst_n = 1'b0;
    #1;
    exp_q = quiet_exp(RST_PC);
    check_bundle();
    @(negedge i_clk);
    i_rst_n = 1'b1; i_stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
